// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder (package ppa_pkg).
// Level/stage counts are derived here so the top and any wrapper agree on latency.
package ppa_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int nlvl(input int width);
      return clog2(width);
   endfunction

   function automatic int nstg(input int width, input int lvl_per_stg);
      return (clog2(width) + lvl_per_stg - 1) / lvl_per_stg;
   endfunction

   // Register count from operand capture to result register.
   function automatic int lat(input int width, input int lvl_per_stg);
      return nstg(width, lvl_per_stg) + 2;
   endfunction

endpackage

// File: rtl/pipelined_prefix_adder_prefix_cell.sv
// Kogge-Stone group operator: combines a higher (g,p) span with the adjacent lower span.
// Purely combinational; one instance per bit per prefix level.
module prefix_cell
   import ppa_pkg::*;
(
   input  gp_t hi,
   input  gp_t lo,
   output gp_t o
);

   assign o.g = hi.g | (hi.p & lo.g);
   assign o.p = hi.p & lo.p;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with global-enable valid/ready flow control.
// Optional status outputs (ovf, zero) are built only when PPA_STATUS_EN is defined.
module pipelined_prefix_adder
   import ppa_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int LVL_PER_STG = 1,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [TAG_W-1:0] tag_out
`ifdef PPA_STATUS_EN
   ,
   output logic             ovf,
   output logic             zero
`endif
);

   localparam int NLVL = nlvl(WIDTH);
   localparam int NSTG = nstg(WIDTH, LVL_PER_STG);

   // Handshake: a beat moves into stage 0 when in_valid & in_ready; a result
   // leaves when out_valid & out_ready. Every stage shifts together on adv and
   // holds (bubbles included) otherwise, so the output is stable while stalled.
   logic adv;
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   // Operand preparation stage
   logic             s0_v;
   logic             s0_c;
   logic [WIDTH-1:0] s0_g;
   logic [WIDTH-1:0] s0_p;
   logic [TAG_W-1:0] s0_tag;
   logic [WIDTH-1:0] b_eff;

   assign b_eff = sub ? ~b : b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_v   <= 1'b0;
         s0_c   <= 1'b0;
         s0_g   <= '0;
         s0_p   <= '0;
         s0_tag <= '0;
      end else if (adv) begin
         s0_v   <= in_valid;
         s0_c   <= sub | cin;
         s0_g   <= a & b_eff;
         s0_p   <= a ^ b_eff;
         s0_tag <= tag_in;
      end
   end

   // Carry-in acts as bit -1 (g=c0, p=0); merging it into bit 0 up front makes
   // every prefix group G[i:0] equal the carry out of bit i.
   logic [WIDTH-1:0] fold_g;
   logic [WIDTH-1:0] fold_p;

   always_comb begin
      fold_g    = s0_g;
      fold_p    = s0_p;
      fold_g[0] = s0_g[0] | (s0_p[0] & s0_c);
      fold_p[0] = 1'b0;
   end

   logic [WIDTH-1:0] lv_g_in  [NLVL];
   logic [WIDTH-1:0] lv_p_in  [NLVL];
   logic [WIDTH-1:0] lv_g_out [NLVL];
   logic [WIDTH-1:0] lv_p_out [NLVL];

   logic             st_v   [NSTG];
   logic             st_c   [NSTG];
   logic [WIDTH-1:0] st_g   [NSTG];
   logic [WIDTH-1:0] st_p   [NSTG];
   logic [WIDTH-1:0] st_h   [NSTG];
   logic [TAG_W-1:0] st_tag [NSTG];

   for (genvar k = 0; k < NLVL; k++) begin : g_lvl
      localparam int D = 1 << k;

      if (k == 0) begin : g_src_prep
         assign lv_g_in[k] = fold_g;
         assign lv_p_in[k] = fold_p;
      end else if ((k % LVL_PER_STG) == 0) begin : g_src_reg
         assign lv_g_in[k] = st_g[k / LVL_PER_STG - 1];
         assign lv_p_in[k] = st_p[k / LVL_PER_STG - 1];
      end else begin : g_src_comb
         assign lv_g_in[k] = lv_g_out[k-1];
         assign lv_p_in[k] = lv_p_out[k-1];
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= D) begin : g_cell
            gp_t hi;
            gp_t lo;
            gp_t o;
            assign hi = {lv_g_in[k][i],   lv_p_in[k][i]};
            assign lo = {lv_g_in[k][i-D], lv_p_in[k][i-D]};
            prefix_cell u_cell (
               .hi (hi),
               .lo (lo),
               .o  (o)
            );
            assign lv_g_out[k][i] = o.g;
            assign lv_p_out[k][i] = o.p;
         end else begin : g_pass
            assign lv_g_out[k][i] = lv_g_in[k][i];
            assign lv_p_out[k][i] = lv_p_in[k][i];
         end
      end
   end

   for (genvar s = 0; s < NSTG; s++) begin : g_stg
      localparam int LAST = (((s + 1) * LVL_PER_STG < NLVL) ? (s + 1) * LVL_PER_STG : NLVL) - 1;

      logic             v_d;
      logic             c_d;
      logic [WIDTH-1:0] h_d;
      logic [TAG_W-1:0] t_d;

      if (s == 0) begin : g_from_prep
         assign v_d = s0_v;
         assign c_d = s0_c;
         assign h_d = s0_p;
         assign t_d = s0_tag;
      end else begin : g_from_stage
         assign v_d = st_v[s-1];
         assign c_d = st_c[s-1];
         assign h_d = st_h[s-1];
         assign t_d = st_tag[s-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_v[s]   <= 1'b0;
            st_c[s]   <= 1'b0;
            st_g[s]   <= '0;
            st_p[s]   <= '0;
            st_h[s]   <= '0;
            st_tag[s] <= '0;
         end else if (adv) begin
            st_v[s]   <= v_d;
            st_c[s]   <= c_d;
            st_g[s]   <= lv_g_out[LAST];
            st_p[s]   <= lv_p_out[LAST];
            st_h[s]   <= h_d;
            st_tag[s] <= t_d;
         end
      end
   end

   // c[i] = G[i:0] after the final level; sum[i] = p[i] ^ c[i-1], c[-1] = c0.
   logic [WIDTH-1:0] fin_g;
   logic [WIDTH-1:0] sum_d;

   assign fin_g = st_g[NSTG-1];
   assign sum_d = st_h[NSTG-1] ^ {fin_g[WIDTH-2:0], st_c[NSTG-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         tag_out   <= '0;
`ifdef PPA_STATUS_EN
         ovf       <= 1'b0;
         zero      <= 1'b0;
`endif
      end else if (adv) begin
         out_valid <= st_v[NSTG-1];
         sum       <= sum_d;
         cout      <= fin_g[WIDTH-1];
         tag_out   <= st_tag[NSTG-1];
`ifdef PPA_STATUS_EN
         ovf       <= fin_g[WIDTH-1] ^ fin_g[WIDTH-2];
         zero      <= ~|sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder: a 32-bit/1-level-per-stage instance for directed
// vectors and flow control, and a 13-bit/2-level-per-stage instance for random operands.
module tb_pipelined_prefix_adder;

   localparam int W   = 32;
   localparam int W2  = 13;
   localparam int TW  = 4;
   localparam int EW  = W + 3 + TW;   // {tag, ovf, zero, cout, sum}
   localparam int EW2 = W2 + 3 + TW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          in_valid, in_ready, cin, sub, out_valid, cout;
   logic          out_ready = 1'b1;
   logic [W-1:0]  a, b, sum;
   logic [TW-1:0] tag_in, tag_out;
   logic          st_ovf, st_zero;

   logic          s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_cout;
   logic          s_out_ready = 1'b1;
   logic [W2-1:0] s_a, s_b, s_sum;
   logic [TW-1:0] s_tag_in, s_tag_out;
   logic          s_st_ovf, s_st_zero;

`ifdef PPA_STATUS_EN
   logic ovf, zero, s_ovf, s_zero;
   assign st_ovf    = ovf;
   assign st_zero   = zero;
   assign s_st_ovf  = s_ovf;
   assign s_st_zero = s_zero;
`else
   assign st_ovf    = 1'b0;
   assign st_zero   = 1'b0;
   assign s_st_ovf  = 1'b0;
   assign s_st_zero = 1'b0;
`endif

   pipelined_prefix_adder #(.WIDTH(W), .LVL_PER_STG(1), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .tag_out(tag_out)
`ifdef PPA_STATUS_EN
      , .ovf(ovf), .zero(zero)
`endif
   );

   pipelined_prefix_adder #(.WIDTH(W2), .LVL_PER_STG(2), .TAG_W(TW)) dut13 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .tag_in(s_tag_in),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout), .tag_out(s_tag_out)
`ifdef PPA_STATUS_EN
      , .ovf(s_ovf), .zero(s_zero)
`endif
   );

   int checks   = 0;
   int failures = 0;
   logic [EW-1:0]  exp_q[$];
   logic [EW2-1:0] exp2_q[$];
   int rdy_mode = 0;
   int pat_i    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] exp32(input logic [W-1:0] s, input logic c, input logic o,
                                           input logic z, input logic [TW-1:0] t);
`ifdef PPA_STATUS_EN
      return {t, o, z, c, s};
`else
      return {t, 2'b00, c, s};
`endif
   endfunction

   // Reference for the 13-bit instance: plain integer addition of a + b' + c0.
   function automatic logic [EW2-1:0] model13(input logic [W2-1:0] x, input logic [W2-1:0] y,
                                              input logic ci, input logic s, input logic [TW-1:0] t);
      logic [W2-1:0] yb;
      logic [W2:0]   r;
      logic          ov, zr;
      yb = s ? ~y : y;
      r  = {1'b0, x} + {1'b0, yb} + {{W2{1'b0}}, (s | ci)};
      ov = (x[W2-1] == yb[W2-1]) && (r[W2-1] != x[W2-1]);
      zr = (r[W2-1:0] == '0);
`ifndef PPA_STATUS_EN
      ov = 1'b0;
      zr = 1'b0;
`endif
      return {t, ov, zr, r[W2], r[W2-1:0]};
   endfunction

   // Per-cycle out_ready driving: mode 1 is the 1,0,0,1 stall pattern.
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) begin
         out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
         pat_i++;
      end else begin
         out_ready = 1'b1;
      end
      s_out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send32(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                         input logic [TW-1:0] t, input logic [EW-1:0] e);
      int n;
      a = x; b = y; cin = ci; sub = s; tag_in = t; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         n++;
         if (n > 200) begin
            chk("accept_timeout", in_ready, 1);
            break;
         end
      end
   endtask

   task automatic send13(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic ci, input logic s,
                         input logic [TW-1:0] t);
      int n;
      s_a = x; s_b = y; s_cin = ci; s_sub = s; s_tag_in = t; s_in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (s_in_ready) begin
            exp2_q.push_back(model13(x, y, ci, s, t));
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         n++;
         if (n > 200) begin
            chk("accept13_timeout", s_in_ready, 1);
            break;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 1000) chk("drain_timeout", exp_q.size() + exp2_q.size(), 0);
   endtask

   // Monitor for the 32-bit instance: retire check, stall stability, in_ready rule.
   logic          stalled = 1'b0;
   logic [EW-1:0] held;
   always @(negedge clk) begin
      logic [EW-1:0] act;
      act = {tag_out, st_ovf, st_zero, cout, sum};
      if (rst_n) begin
         chk("in_ready_rule", in_ready, !out_valid | out_ready);
         if (stalled) chk("stall_hold", {out_valid, act}, {1'b1, held});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_without_beat", out_valid, 0);
            else chk("result32", act, exp_q.pop_front());
         end
         stalled = out_valid && !out_ready;
         held    = act;
      end else begin
         stalled = 1'b0;
      end
   end

   always @(negedge clk) begin
      logic [EW2-1:0] act2;
      act2 = {s_tag_out, s_st_ovf, s_st_zero, s_cout, s_sum};
      if (rst_n && s_out_valid && s_out_ready) begin
         if (exp2_q.size() == 0) chk("out13_without_beat", s_out_valid, 0);
         else chk("result13", act2, exp2_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag_in = '0;
      s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_tag_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_tag", tag_out, 0);
      chk("rst_out_valid13", s_out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full carry ripple and latency from an empty pipeline
      send32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h1, exp32(32'h0, 1'b1, 1'b0, 1'b1, 4'h1));
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, 7);
      drain();

      // Directed vectors back to back
      send32(32'd5, 32'd7, 1'b1, 1'b1, 4'h2, exp32(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'h2));
      send32(32'd7, 32'd5, 1'b0, 1'b1, 4'h3, exp32(32'h2, 1'b1, 1'b0, 1'b0, 4'h3));
      send32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h4, exp32(32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'h4));
      send32(32'h0, 32'h0, 1'b1, 1'b0, 4'h5, exp32(32'h1, 1'b0, 1'b0, 1'b0, 4'h5));
      send32(32'h0, 32'h0, 1'b0, 1'b1, 4'h6, exp32(32'h0, 1'b1, 1'b0, 1'b1, 4'h6));
      send32(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'h7, exp32(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 4'h7));
      send32(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 4'h8, exp32(32'h0, 1'b1, 1'b0, 1'b1, 4'h8));
      send32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4'h9, exp32(32'h2345_6789, 1'b0, 1'b0, 1'b0, 4'h9));
      in_valid = 1'b0;
      drain();

      // 20 beats against the 1,0,0,1 out_ready pattern: i + 0xFFFF_FFF0
      rdy_mode = 1;
      pat_i    = 0;
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] es;
         es = (i < 16) ? (32'hFFFF_FFF0 + W'(i)) : W'(i - 16);
         send32(W'(i), 32'hFFFF_FFF0, 1'b0, 1'b0, TW'(i),
                exp32(es, (i >= 16), 1'b0, (i == 16), TW'(i)));
      end
      in_valid = 1'b0;
      drain();
      rdy_mode = 0;

      // Reset with beats in flight: nothing may emerge afterwards
      for (int i = 0; i < 4; i++)
         send32(W'(i), W'(i), 1'b0, 1'b0, TW'(i), exp32(W'(2 * i), 1'b0, 1'b0, (i == 0), TW'(i)));
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_sum", sum, 0);
      chk("async_rst_tag", tag_out, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         chk("post_rst_quiet", out_valid, 0);
      end

      // Random operands on the 13-bit, 2-levels-per-stage instance
      for (int i = 0; i < 1000; i++) begin
         send13(W2'($urandom_range(0, 8191)), W2'($urandom_range(0, 8191)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'(i));
      end
      s_in_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
